menu_nav_fsm: RTL and testbench
===============================

// Module: menu_nav_fsm
// PURPOSE
//  Parametrised front-end menu controller. Sequences TITLE -> CAR_SELECT -> CONTROL_SELECT -> GAME.
//  Edge-detects the four buttons internally, so each press makes exactly one move.
//  Keeps a wrap-around cursor per selection screen, latches the confirmed car/control indices,
//  and drives screen-visibility flags, arrow sprite position and lap-timer start for the draw/timer blocks.
// PARAMETERS
//  N_CARS       4    number of selectable cars (>=2)
//  N_CTRLS      2    number of selectable control schemes (>=2)
//  POS_W        12   width of arrow_xpos/arrow_ypos
//  ARROW_X0     208  arrow x for cursor index 0
//  ARROW_DX     192  x pitch between consecutive options
//  CAR_ARROW_Y  480  arrow y on CAR_SELECT
//  CTRL_ARROW_Y 576  arrow y on CONTROL_SELECT
// PORTS
//  pclk            in   1                clock
//  rst             in   1                reset, synchronous, active-high
//  btnU            in   1                confirm / advance (level, pre-synchronised)
//  btnD            in   1                back (used only with MENU_BACK_EN)
//  btnL            in   1                cursor left
//  btnR            in   1                cursor right
//  title_visible   out  1                TITLE screen shown
//  car_sel_visible out  1                CAR_SELECT screen + car sprites shown
//  ctrl_sel_visible out 1                CONTROL_SELECT screen shown
//  game_visible    out  1                track + player shown
//  arrow_visible   out  1                arrow sprite shown
//  arrow_xpos      out  POS_W            arrow x
//  arrow_ypos      out  POS_W            arrow y
//  car             out  $clog2(N_CARS)   confirmed car index
//  control         out  $clog2(N_CTRLS)  confirmed control index
//  lap_timer_start out  1                one-cycle pulse on GAME entry
// BEHAVIOUR
//  - Reset: state=TITLE, both cursors=0, car=0, control=0, title_visible=1, all other flags 0,
//    arrow_xpos=ARROW_X0, arrow_ypos=0, lap_timer_start=0.
//  - press_X = btnX & ~btnX_q, where btnX_q is the previous-cycle sample (reset 0). A held button acts once.
//  - Priority when several presses coincide: U > D > L > R; only the winner takes effect.
//  - All outputs registered. Press sampled in cycle n -> new state, cursor and outputs visible in cycle n+1.
//  - TITLE:  press_U -> CAR_SELECT, car cursor := 0.
//  - CAR_SELECT:
//      press_R: cursor+1, N_CARS-1 wraps to 0. press_L: cursor-1, 0 wraps to N_CARS-1.
//      press_U: car := cursor; -> CONTROL_SELECT; ctrl cursor := 0.
//  - CONTROL_SELECT: same L/R wrap over N_CTRLS.
//      press_U: control := cursor; -> GAME; lap_timer_start=1 for exactly that entry cycle.
//  - GAME:   press_U -> TITLE. car and control keep their values until the next confirm.
//  - Visibility flags are one-hot on state. arrow_visible=1 only in the two select states.
//  - arrow_xpos = ARROW_X0 + cursor*ARROW_DX, truncated to POS_W.
//    arrow_ypos = CAR_ARROW_Y or CTRL_ARROW_Y per screen; it holds its last value elsewhere.
//  - Reset asserted mid-menu overrides every press that cycle. Illegal state encoding -> TITLE.
// CONFIGURATION
//  MENU_BACK_EN defined:
//    press_D goes back one step: CONTROL_SELECT -> CAR_SELECT (car cursor restored to current car),
//    CAR_SELECT -> TITLE, GAME -> CONTROL_SELECT. No lap pulse on any back move.
//  MENU_BACK_EN undefined: btnD is ignored and the logic for it is not built.
// STRUCTURE
//  - menu_pkg: state encoding (TITLE=2'b00, GAME=2'b01, CONTROL_SELECT=2'b10, CAR_SELECT=2'b11)
//    and button-index constants.
//  - Sub-module btn_edge (parametrised width, here 4): registers the previous sample and outputs the
//    press pulses. Next-state and output logic stay in this module.
// TESTING
//  1. rst 1 cycle -> title_visible=1, car=0, control=0, lap_timer_start=0.
//  2. U, R, R, U, R, U (one press each, idle gaps) -> car=2, control=1, game_visible=1.
//     lap_timer_start high exactly 1 cycle. Arrow at x=592 y=480 after R,R.
//  3. CAR_SELECT, press L at cursor 0 -> arrow_xpos=208+3*192=784. Then R -> 208.
//  4. btnU held 10 cycles from TITLE -> only CAR_SELECT reached. Same cycle L+R -> only L applied.
//  5. rst pulsed while in CONTROL_SELECT with btnU rising the same cycle -> TITLE next cycle, no lap pulse.
//  6. With MENU_BACK_EN: GAME, press D -> CONTROL_SELECT. Press D -> CAR_SELECT, arrow on the latched car.
//     Without MENU_BACK_EN: press D -> no change.

Source files
------------

// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared state encoding and button indices for the menu controller
package menu_pkg;

   typedef enum logic [1:0] {
      ST_TITLE    = 2'b00,
      ST_GAME     = 2'b01,
      ST_CTRL_SEL = 2'b10,
      ST_CAR_SEL  = 2'b11
   } menu_state_t;

   localparam int N_BTNS = 4;
   localparam int BTN_R  = 0;
   localparam int BTN_L  = 1;
   localparam int BTN_D  = 2;
   localparam int BTN_U  = 3;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge press detector; one pulse per button press
module btn_edge #(
   parameter int W = 4
) (
   input  logic         pclk,
   input  logic         rst,
   input  logic [W-1:0] btn,
   output logic [W-1:0] press
);

   logic [W-1:0] btn_q;

   always_ff @(posedge pclk) begin
      if (rst) begin
         btn_q <= '0;
      end else begin
         btn_q <= btn;
      end
   end

   assign press = btn & ~btn_q;

endmodule

// File: rtl/menu_nav_fsm.sv
// rtl/menu_nav_fsm.sv - title/car/control/game menu sequencer with arrow cursor
// Optional back navigation on btnD when MENU_BACK_EN is defined.
module menu_nav_fsm
   import menu_pkg::*;
#(
   parameter int N_CARS       = 4,
   parameter int N_CTRLS      = 2,
   parameter int POS_W        = 12,
   parameter int ARROW_X0     = 208,
   parameter int ARROW_DX     = 192,
   parameter int CAR_ARROW_Y  = 480,
   parameter int CTRL_ARROW_Y = 576
) (
   input  logic                       pclk,
   input  logic                       rst,
   input  logic                       btnU,
   input  logic                       btnD,
   input  logic                       btnL,
   input  logic                       btnR,
   output logic                       title_visible,
   output logic                       car_sel_visible,
   output logic                       ctrl_sel_visible,
   output logic                       game_visible,
   output logic                       arrow_visible,
   output logic [POS_W-1:0]           arrow_xpos,
   output logic [POS_W-1:0]           arrow_ypos,
   output logic [$clog2(N_CARS)-1:0]  car,
   output logic [$clog2(N_CTRLS)-1:0] control,
   output logic                       lap_timer_start
);

   localparam int CAR_W  = $clog2(N_CARS);
   localparam int CTRL_W = $clog2(N_CTRLS);
   localparam logic [CAR_W-1:0]  CAR_MAX  = CAR_W'(N_CARS - 1);
   localparam logic [CAR_W-1:0]  CAR_ONE  = CAR_W'(1);
   localparam logic [CTRL_W-1:0] CTRL_MAX = CTRL_W'(N_CTRLS - 1);
   localparam logic [CTRL_W-1:0] CTRL_ONE = CTRL_W'(1);

   function automatic logic [POS_W-1:0] arrow_x(input int idx);
      return POS_W'(ARROW_X0 + idx * ARROW_DX);
   endfunction

   logic [N_BTNS-1:0] btn_vec;
   logic [N_BTNS-1:0] press;
   logic go_u, go_d, go_l, go_r;

   menu_state_t       state, nxt_state;
   logic [CAR_W-1:0]  car_cur, nxt_car_cur, nxt_car;
   logic [CTRL_W-1:0] ctrl_cur, nxt_ctrl_cur, nxt_control;
   logic              lap_go;

`ifdef MENU_BACK_EN
   assign btn_vec = {btnU, btnD, btnL, btnR};
   assign go_d    = press[BTN_D] & ~press[BTN_U];
`else
   // btnD is tied off so its edge flop and back paths fold away
   logic unused_btn_d;
   assign unused_btn_d = btnD;
   assign btn_vec      = {btnU, 1'b0, btnL, btnR};
   assign go_d         = 1'b0;
`endif

   btn_edge #(.W(N_BTNS)) u_btn_edge (
      .pclk  (pclk),
      .rst   (rst),
      .btn   (btn_vec),
      .press (press)
   );

   // Priority U > D > L > R: only one winner acts per cycle
   assign go_u = press[BTN_U];
   assign go_l = press[BTN_L] & ~go_u & ~go_d;
   assign go_r = press[BTN_R] & ~go_u & ~go_d & ~press[BTN_L];

   always_comb begin
      nxt_state    = state;
      nxt_car_cur  = car_cur;
      nxt_ctrl_cur = ctrl_cur;
      nxt_car      = car;
      nxt_control  = control;
      lap_go       = 1'b0;
      case (state)
         ST_TITLE: begin
            if (go_u) begin
               nxt_state   = ST_CAR_SEL;
               nxt_car_cur = '0;
            end
         end
         ST_CAR_SEL: begin
            if (go_u) begin
               nxt_car      = car_cur;
               nxt_state    = ST_CTRL_SEL;
               nxt_ctrl_cur = '0;
            end else if (go_d) begin
               nxt_state = ST_TITLE;
            end else if (go_l) begin
               nxt_car_cur = (car_cur == '0) ? CAR_MAX : car_cur - CAR_ONE;
            end else if (go_r) begin
               nxt_car_cur = (car_cur == CAR_MAX) ? '0 : car_cur + CAR_ONE;
            end
         end
         ST_CTRL_SEL: begin
            if (go_u) begin
               nxt_control = ctrl_cur;
               nxt_state   = ST_GAME;
               lap_go      = 1'b1;
            end else if (go_d) begin
               nxt_state   = ST_CAR_SEL;
               nxt_car_cur = car;
            end else if (go_l) begin
               nxt_ctrl_cur = (ctrl_cur == '0) ? CTRL_MAX : ctrl_cur - CTRL_ONE;
            end else if (go_r) begin
               nxt_ctrl_cur = (ctrl_cur == CTRL_MAX) ? '0 : ctrl_cur + CTRL_ONE;
            end
         end
         ST_GAME: begin
            if (go_u) begin
               nxt_state = ST_TITLE;
            end else if (go_d) begin
               nxt_state = ST_CTRL_SEL;
            end
         end
         default: nxt_state = ST_TITLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state            <= ST_TITLE;
         car_cur          <= '0;
         ctrl_cur         <= '0;
         car              <= '0;
         control          <= '0;
         title_visible    <= 1'b1;
         car_sel_visible  <= 1'b0;
         ctrl_sel_visible <= 1'b0;
         game_visible     <= 1'b0;
         arrow_visible    <= 1'b0;
         arrow_xpos       <= POS_W'(ARROW_X0);
         arrow_ypos       <= '0;
         lap_timer_start  <= 1'b0;
      end else begin
         state            <= nxt_state;
         car_cur          <= nxt_car_cur;
         ctrl_cur         <= nxt_ctrl_cur;
         car              <= nxt_car;
         control          <= nxt_control;
         title_visible    <= (nxt_state == ST_TITLE);
         car_sel_visible  <= (nxt_state == ST_CAR_SEL);
         ctrl_sel_visible <= (nxt_state == ST_CTRL_SEL);
         game_visible     <= (nxt_state == ST_GAME);
         arrow_visible    <= (nxt_state == ST_CAR_SEL) || (nxt_state == ST_CTRL_SEL);
         lap_timer_start  <= lap_go;
         // Arrow tracks the active screen's cursor and holds on title/game
         if (nxt_state == ST_CAR_SEL) begin
            arrow_xpos <= arrow_x(int'(nxt_car_cur));
            arrow_ypos <= POS_W'(CAR_ARROW_Y);
         end else if (nxt_state == ST_CTRL_SEL) begin
            arrow_xpos <= arrow_x(int'(nxt_ctrl_cur));
            arrow_ypos <= POS_W'(CTRL_ARROW_Y);
         end
      end
   end

endmodule

// File: tb/tb_menu_nav_fsm.sv
// tb/tb_menu_nav_fsm.sv - vector table, corner sequences and random run against a screen-level model
module tb_menu_nav_fsm;

   localparam int N_CARS  = 4;
   localparam int N_CTRLS = 2;
   localparam int POS_W   = 12;

   logic pclk = 1'b0;
   logic rst = 1'b1;
   logic btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
   logic title_visible, car_sel_visible, ctrl_sel_visible, game_visible, arrow_visible;
   logic [POS_W-1:0] arrow_xpos, arrow_ypos;
   logic [1:0] car;
   logic [0:0] control;
   logic lap_timer_start;

   int n_chk = 0;
   int n_fail = 0;

   menu_nav_fsm #(
      .N_CARS(N_CARS), .N_CTRLS(N_CTRLS), .POS_W(POS_W), .ARROW_X0(208),
      .ARROW_DX(192), .CAR_ARROW_Y(480), .CTRL_ARROW_Y(576)
   ) dut (
      .pclk(pclk), .rst(rst), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
      .title_visible(title_visible), .car_sel_visible(car_sel_visible),
      .ctrl_sel_visible(ctrl_sel_visible), .game_visible(game_visible),
      .arrow_visible(arrow_visible), .arrow_xpos(arrow_xpos), .arrow_ypos(arrow_ypos),
      .car(car), .control(control), .lap_timer_start(lap_timer_start)
   );

   always #5 pclk = ~pclk;

   // Screen model: 0 title, 1 car select, 2 control select, 3 game
`ifdef MENU_BACK_EN
   localparam bit BACK_EN = 1'b1;
`else
   localparam bit BACK_EN = 1'b0;
`endif
   int m_scr, m_ccur, m_kcur, m_car, m_ctrl, m_x, m_y;
   bit m_lap, pu, pd, pl, pr;

   task automatic model_step(input bit r_i, input bit u, input bit d, input bit l, input bit r);
      bit eu, ed, el, er;
      string win;
      if (r_i) begin
         m_scr = 0; m_ccur = 0; m_kcur = 0; m_car = 0; m_ctrl = 0;
         m_x = 208; m_y = 0; m_lap = 0;
         pu = 0; pd = 0; pl = 0; pr = 0;
         return;
      end
      eu = u && !pu; ed = d && !pd; el = l && !pl; er = r && !pr;
      pu = u; pd = d; pl = l; pr = r;
      m_lap = 0;
      if (eu) win = "U";
      else if (BACK_EN && ed) win = "D";
      else if (el) win = "L";
      else if (er) win = "R";
      else win = "";
      case (m_scr)
         0: if (win == "U") begin m_scr = 1; m_ccur = 0; end
         1: begin
            if (win == "U") begin m_car = m_ccur; m_scr = 2; m_kcur = 0; end
            else if (win == "D") m_scr = 0;
            else if (win == "L") m_ccur = (m_ccur + N_CARS - 1) % N_CARS;
            else if (win == "R") m_ccur = (m_ccur + 1) % N_CARS;
         end
         2: begin
            if (win == "U") begin m_ctrl = m_kcur; m_scr = 3; m_lap = 1; end
            else if (win == "D") begin m_scr = 1; m_ccur = m_car; end
            else if (win == "L") m_kcur = (m_kcur + N_CTRLS - 1) % N_CTRLS;
            else if (win == "R") m_kcur = (m_kcur + 1) % N_CTRLS;
         end
         default: begin
            if (win == "U") m_scr = 0;
            else if (win == "D") m_scr = 2;
         end
      endcase
      if (m_scr == 1) begin m_x = (208 + m_ccur * 192) % 4096; m_y = 480; end
      if (m_scr == 2) begin m_x = (208 + m_kcur * 192) % 4096; m_y = 576; end
   endtask

   task automatic tick(input bit r_i, input bit u, input bit d, input bit l, input bit r);
      rst = r_i; btnU = u; btnD = d; btnL = l; btnR = r;
      model_step(r_i, u, d, l, r);
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d expected %0d", tag, name, got, exp);
      end
   endtask

   task automatic chk_exp(input string tag, input int scr, input int x, input int y,
                          input int ecar, input int ectrl, input bit lap);
      chk(tag, "title_visible", 32'(title_visible), 32'(scr == 0));
      chk(tag, "car_sel_visible", 32'(car_sel_visible), 32'(scr == 1));
      chk(tag, "ctrl_sel_visible", 32'(ctrl_sel_visible), 32'(scr == 2));
      chk(tag, "game_visible", 32'(game_visible), 32'(scr == 3));
      chk(tag, "arrow_visible", 32'(arrow_visible), 32'(scr == 1 || scr == 2));
      chk(tag, "arrow_xpos", 32'(arrow_xpos), 32'(x));
      chk(tag, "arrow_ypos", 32'(arrow_ypos), 32'(y));
      chk(tag, "car", 32'(car), 32'(ecar));
      chk(tag, "control", 32'(control), 32'(ectrl));
      chk(tag, "lap_timer_start", 32'(lap_timer_start), 32'(lap));
   endtask

   task automatic chk_model(input string tag);
      chk_exp(tag, m_scr, m_x, m_y, m_car, m_ctrl, m_lap);
   endtask

   typedef struct {
      bit rst, u, d, l, r;
      int scr, x, y, ecar, ectrl;
      bit lap;
   } vec_t;

   vec_t tbl[$];

   initial begin
      tbl.push_back('{1,0,0,0,0, 0,208,  0,0,0,0});
      tbl.push_back('{0,0,0,0,0, 0,208,  0,0,0,0});
      tbl.push_back('{0,1,0,0,0, 1,208,480,0,0,0});
      tbl.push_back('{0,0,0,0,0, 1,208,480,0,0,0});
      tbl.push_back('{0,0,0,0,1, 1,400,480,0,0,0});
      tbl.push_back('{0,0,0,0,0, 1,400,480,0,0,0});
      tbl.push_back('{0,0,0,0,1, 1,592,480,0,0,0});
      tbl.push_back('{0,0,0,0,0, 1,592,480,0,0,0});
      tbl.push_back('{0,1,0,0,0, 2,208,576,2,0,0});
      tbl.push_back('{0,0,0,0,0, 2,208,576,2,0,0});
      tbl.push_back('{0,0,0,0,1, 2,400,576,2,0,0});
      tbl.push_back('{0,0,0,0,0, 2,400,576,2,0,0});
      tbl.push_back('{0,1,0,0,0, 3,400,576,2,1,1});
      tbl.push_back('{0,0,0,0,0, 3,400,576,2,1,0});
      tbl.push_back('{0,1,0,0,0, 0,400,576,2,1,0});
      tbl.push_back('{0,0,0,0,0, 0,400,576,2,1,0});
      tbl.push_back('{0,1,0,0,0, 1,208,480,2,1,0});
      tbl.push_back('{0,0,0,0,0, 1,208,480,2,1,0});
      tbl.push_back('{0,0,0,1,0, 1,784,480,2,1,0});
      tbl.push_back('{0,0,0,0,0, 1,784,480,2,1,0});
      tbl.push_back('{0,0,0,0,1, 1,208,480,2,1,0});
      tbl.push_back('{0,0,0,0,0, 1,208,480,2,1,0});
      tbl.push_back('{0,0,0,1,1, 1,784,480,2,1,0});
      tbl.push_back('{0,0,0,0,0, 1,784,480,2,1,0});
      tbl.push_back('{0,0,0,0,1, 1,208,480,2,1,0});

      #1;
      foreach (tbl[i]) begin
         tick(tbl[i].rst, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r);
         chk_exp($sformatf("vec%0d", i), tbl[i].scr, tbl[i].x, tbl[i].y,
                 tbl[i].ecar, tbl[i].ectrl, tbl[i].lap);
      end

      // Held confirm from title only advances once
      tick(1,0,0,0,0);
      for (int i = 0; i < 10; i++) begin
         tick(0,1,0,0,0);
         chk_exp($sformatf("held_u%0d", i), 1, 208, 480, 0, 0, 0);
      end
      tick(0,0,0,0,0);

      // Reset wins over a confirm press in control select
      tick(1,0,0,0,0);
      tick(0,1,0,0,0);
      tick(0,0,0,0,0);
      tick(0,1,0,0,0);
      tick(0,0,0,0,0);
      chk_exp("in_ctrl", 2, 208, 576, 0, 0, 0);
      tick(1,1,0,0,0);
      chk_exp("rst_over_u", 0, 208, 0, 0, 0, 0);
      tick(0,1,0,0,0);
      chk_model("after_rst");
      tick(0,0,0,0,0);

      // Back button from game
      tick(1,0,0,0,0);
      tick(0,1,0,0,0); tick(0,0,0,0,0);
      tick(0,0,0,0,1); tick(0,0,0,0,0);
      tick(0,1,0,0,0); tick(0,0,0,0,0);
      tick(0,1,0,0,0);
      chk_exp("game_entry", 3, 208, 576, 1, 0, 1);
      tick(0,0,0,0,0);
      tick(0,0,1,0,0);
`ifdef MENU_BACK_EN
      chk_exp("back_game", 2, 208, 576, 1, 0, 0);
      tick(0,0,0,0,0);
      tick(0,0,1,0,0);
      chk_exp("back_ctrl", 1, 400, 480, 1, 0, 0);
`else
      chk_exp("d_ignored", 3, 208, 576, 1, 0, 0);
      tick(0,0,0,0,0);
      tick(0,0,1,0,0);
      chk_exp("d_ignored2", 3, 208, 576, 1, 0, 0);
`endif
      tick(0,0,0,0,0);
      chk_model("seq_end");

      // Random presses with occasional reset
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 199) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         chk_model("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
